// File: rtl/nes_controller_responder.sv
// NES joypad controller-side responder: serialises buttons on latch/pulse.
// Optional turbo A/B modulation is built when NES_TURBO_EN is defined.
module nes_controller_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BITS    = 8,
  parameter int TURBO_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] buttons,
  input  logic                nes_latch,
  input  logic                nes_pulse,
`ifdef NES_TURBO_EN
  input  logic [1:0]          turbo_mask,
`endif
  output logic                nes_data,
  output logic                busy,
  output logic [3:0]          bit_count,
  output logic                frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [SYNC_STAGES-1:0] latchSync, pulseSync;
  logic latchQ, pulseQ;
  logic latchNow, pulseNow;
  logic latchRise, latchFall, pulseRise;

  logic [NUM_BITS-1:0] shReg, shNext, loadVal;
  logic [3:0] cntNext;
  logic dataNext, busyNext, doneNext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latchSync <= '0;
      pulseSync <= '0;
      latchQ    <= 1'b0;
      pulseQ    <= 1'b0;
    end else begin
      latchSync <= {latchSync[SYNC_STAGES-2:0], nes_latch};
      pulseSync <= {pulseSync[SYNC_STAGES-2:0], nes_pulse};
      latchQ    <= latchNow;
      pulseQ    <= pulseNow;
    end
  end

  assign latchNow  = latchSync[SYNC_STAGES-1];
  assign pulseNow  = pulseSync[SYNC_STAGES-1];
  assign latchRise = latchNow & ~latchQ;
  assign latchFall = ~latchNow & latchQ;
  assign pulseRise = pulseNow & ~pulseQ;

`ifdef NES_TURBO_EN
  localparam int CW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [CW-1:0] frameCnt;
  logic phase;
  logic frameStart;

  assign frameStart = (state == LOAD) && latchFall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frameCnt <= '0;
      phase    <= 1'b0;
    end else if (frameStart) begin
      if (frameCnt == CW'(TURBO_DIV - 1)) begin
        frameCnt <= '0;
        phase    <= ~phase;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

  // Active-low: a turbo button reads as released during phase 1
  always_comb begin
    loadVal = ~buttons;
    if (phase) begin
      if (turbo_mask[0]) loadVal[0] = 1'b1;
      if (turbo_mask[1]) loadVal[1] = 1'b1;
    end
  end
`else
  assign loadVal = ~buttons;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shReg      <= '1;
      bit_count  <= 4'd0;
      nes_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= stateNext;
      shReg      <= shNext;
      bit_count  <= cntNext;
      nes_data   <= dataNext;
      busy       <= busyNext;
      frame_done <= doneNext;
    end
  end

  // Latch rise outranks everything, including a same-cycle pulse
  always_comb begin
    stateNext = state;
    shNext    = shReg;
    cntNext   = bit_count;
    if (latchRise) begin
      stateNext = LOAD;
      shNext    = loadVal;
      cntNext   = 4'd0;
    end else begin
      unique case (state)
        LOAD: begin
          shNext = loadVal;
          if (latchFall) begin
            stateNext = SHIFT;
            cntNext   = 4'd0;
          end
        end
        SHIFT: begin
          if (pulseRise) begin
            shNext  = {1'b1, shReg[NUM_BITS-1:1]};
            cntNext = bit_count + 4'd1;
            if (cntNext == 4'(NUM_BITS)) stateNext = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busyNext = (stateNext == LOAD) || (stateNext == SHIFT);
    dataNext = busyNext ? shNext[0] : 1'b1;
    doneNext = (state == SHIFT) && (stateNext == DONE);
  end

endmodule

// File: tb/tb_nes_controller_responder.sv
// Randomised + directed bench for nes_controller_responder.
// Frame-level model: pressed vector plus bit index, delayed by the sync depth.
module tb_nes_controller_responder;
  localparam int S    = 2;
  localparam int N    = 8;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       nes_latch = 1'b0;
  logic       nes_pulse = 1'b0;
`ifdef NES_TURBO_EN
  logic [1:0] turbo_mask = 2'b00;
`endif
  logic       nes_data;
  logic       busy;
  logic [3:0] bit_count;
  logic       frame_done;

  nes_controller_responder #(
    .SYNC_STAGES(S),
    .NUM_BITS(N),
    .TURBO_DIV(TDIV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .buttons(buttons),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
`ifdef NES_TURBO_EN
    .turbo_mask(turbo_mask),
`endif
    .nes_data(nes_data),
    .busy(busy),
    .bit_count(bit_count),
    .frame_done(frame_done)
  );

  int vecs = 0;
  int errs = 0;
  int fdCount = 0;
  bit checkEn = 1'b0;

  // Model: 0 idle, 1 latched, 2 shifting, 3 done
  int mode = 0;
  int mCnt = 0;
  int falls = 0;
  logic [7:0] mFrame = 8'h00;
  logic mFd = 1'b0;
  logic [S:0] lH = '0;
  logic [S:0] pH = '0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] effBtn(int f);
    logic [7:0] b;
    b = buttons;
`ifdef NES_TURBO_EN
    if (((f / TDIV) % 2) == 1) b = b & ~{6'b0, turbo_mask};
`endif
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      lH = '0; pH = '0; mode = 0; mCnt = 0;
      mFrame = 8'h00; mFd = 1'b0; falls = 0;
    end else begin
      logic l, lp, p, pp;
      l = lH[S-1]; lp = lH[S]; p = pH[S-1]; pp = pH[S];
      mFd = 1'b0;
      if (l && !lp) begin
        mode = 1; mCnt = 0; mFrame = effBtn(falls);
      end else if (mode == 1) begin
        mFrame = effBtn(falls);
        if (!l && lp) begin
          mode = 2; mCnt = 0; falls++;
        end
      end else if (mode == 2 && p && !pp) begin
        mCnt++;
        if (mCnt == N) begin
          mode = 3; mFd = 1'b1;
        end
      end
      lH = {lH[S-1:0], nes_latch};
      pH = {pH[S-1:0], nes_pulse};
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) fdCount++;
    if (checkEn) begin
      logic bM, dM;
      bM = (mode == 1) || (mode == 2);
      dM = bM ? ~mFrame[mCnt] : 1'b1;
      check("nes_data", {7'b0, nes_data}, {7'b0, dM});
      check("busy", {7'b0, busy}, {7'b0, bM});
      check("bit_count", {4'b0, bit_count}, 8'(mCnt));
      check("frame_done", {7'b0, frame_done}, {7'b0, mFd});
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latchFrame(int hi);
    nes_latch = 1'b1;
    tick(hi);
    nes_latch = 1'b0;
    tick(S + 2);
  endtask

  task automatic pulse();
    nes_pulse = 1'b1;
    tick(2);
    nes_pulse = 1'b0;
    tick(2);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] turboSeq;
    int f0;
    tick(2);
    check("reset_data", {7'b0, nes_data}, 8'h01);
    check("reset_busy", {7'b0, busy}, 8'h00);
    check("reset_count", {4'b0, bit_count}, 8'h00);
    reset_n = 1'b1;
    checkEn = 1'b1;
    tick(2);

    // Button vector 0x09 serialised LSB first, active low
    buttons = 8'h09;
    seq = 8'b1111_0110;
    f0 = fdCount;
    latchFrame(3);
    for (int i = 0; i < 8; i++) begin
      check("seq09", {7'b0, nes_data}, {7'b0, seq[i]});
      pulse();
    end
    check("seq09_tail", {7'b0, nes_data}, 8'h01);
    check("seq09_count", {4'b0, bit_count}, 8'd8);
    check("seq09_done", 8'(fdCount - f0), 8'd1);

    // All pressed, extra pulses saturate
    buttons = 8'hFF;
    latchFrame(2);
    for (int i = 0; i < 10; i++) begin
      check("seqFF", {7'b0, nes_data}, (i < 8) ? 8'h00 : 8'h01);
      pulse();
    end
    check("seqFF_count", {4'b0, bit_count}, 8'd8);

    // Abort mid-frame
    buttons = 8'h0F;
    latchFrame(2);
    repeat (4) pulse();
    f0 = fdCount;
    nes_latch = 1'b1;
    tick(S + 2);
    check("abort_data", {7'b0, nes_data}, 8'h00);
    check("abort_count", {4'b0, bit_count}, 8'd0);
    check("abort_nodone", 8'(fdCount - f0), 8'd0);
    nes_latch = 1'b0;
    tick(4);
    repeat (8) pulse();

    // Latch and pulse rising together
    buttons = 8'h01;
    nes_latch = 1'b1;
    nes_pulse = 1'b1;
    tick(2);
    nes_pulse = 1'b0;
    tick(2);
    check("coinc_data", {7'b0, nes_data}, 8'h00);
    check("coinc_count", {4'b0, bit_count}, 8'd0);
    repeat (2) pulse();
    check("latchhi_data", {7'b0, nes_data}, 8'h00);
    nes_latch = 1'b0;
    tick(4);
    pulse();
    check("coinc_bit1", {7'b0, nes_data}, 8'h01);
    check("coinc_bit1cnt", {4'b0, bit_count}, 8'd1);

    // Asynchronous reset while shifting
    buttons = 8'hA5;
    latchFrame(2);
    repeat (3) pulse();
    check("pre_reset_cnt", {4'b0, bit_count}, 8'd3);
    reset_n = 1'b0;
    #1;
    check("async_data", {7'b0, nes_data}, 8'h01);
    check("async_busy", {7'b0, busy}, 8'h00);
    check("async_count", {4'b0, bit_count}, 8'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    repeat (2) pulse();
    check("post_reset_busy", {7'b0, busy}, 8'h00);
    check("post_reset_data", {7'b0, nes_data}, 8'h01);

    // Turbo A over eight frames
    doReset();
    buttons = 8'h01;
`ifdef NES_TURBO_EN
    turbo_mask = 2'b01;
    turboSeq = 8'hF0;
`else
    turboSeq = 8'h00;
`endif
    for (int f = 0; f < 8; f++) begin
      latchFrame(2);
      check("turbo_first", {7'b0, nes_data}, {7'b0, turboSeq[f]});
      pulse();
    end

    // Randomised frames, aborts and coincident edges
    doReset();
    repeat (150) begin
      int n;
      buttons = 8'($urandom);
`ifdef NES_TURBO_EN
      turbo_mask = 2'($urandom);
`endif
      nes_latch = 1'b1;
      if ($urandom_range(0, 3) == 0) nes_pulse = 1'b1;
      tick($urandom_range(1, 4));
      nes_latch = 1'b0;
      if ($urandom_range(0, 3) == 0) nes_pulse = 1'b1;
      tick($urandom_range(1, 3));
      nes_pulse = 1'b0;
      tick($urandom_range(0, 3));
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) begin
        nes_pulse = 1'b1;
        if ($urandom_range(0, 7) == 0) buttons = 8'($urandom);
        tick($urandom_range(1, 3));
        nes_pulse = 1'b0;
        tick($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) break;
      end
    end
    tick(6);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
